config_sram_loader: RTL and testbench

//  Serial configuration loader for the SRAM bits that drive the SRAMin gates of a routing block's transmission gates.

---
 rtl/cfg_loader_pkg.sv | 24 ++
 rtl/cfg_shift_reg.sv | 22 ++
 rtl/config_sram_loader.sv | 132 +++++++++++++
 tb/tb_config_sram_loader.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the serial configuration SRAM loader:
// FSM state encoding, default frame-start pattern and a width helper.
package cfg_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_LOAD,
        ST_PARITY,
        ST_COMMIT,
        ST_ERROR
    } state_e;

    localparam logic [7:0] DEFAULT_SYNC_WORD = 8'hB5;

    // Smallest r with 2**r >= v; usable in constant expressions.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/cfg_shift_reg.sv
// Serial-in, parallel-out shift register with clear and shift enable.
// New bits enter at the LSB, so the oldest bit ends up at the MSB.
module cfg_shift_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            q <= '0;
        end else if (en) begin
            q <= {q[WIDTH-2:0], din};
        end
    end

endmodule

// File: rtl/config_sram_loader.sv
// Framed bit-serial loader for transmission-gate SRAM bits; the payload is
// parity-checked in a shadow register and committed to sram_out in one edge.
//
// state  | meaning
// IDLE   | waiting for cfg_start, sram_out holds last good configuration
// SYNC   | hunting for the frame-start pattern, bounded by SYNC_TIMEOUT
// LOAD   | shifting NUM_BITS payload bits into the shadow register
// PARITY | taking the even-parity bit
// COMMIT | shadow copied to sram_out, cfg_done set
// ERROR  | cfg_error set, sram_out untouched
module config_sram_loader
    import cfg_loader_pkg::*;
#(
    parameter int         NUM_BITS     = 64,
    parameter logic [7:0] SYNC_WORD    = DEFAULT_SYNC_WORD,
    parameter int         SYNC_TIMEOUT = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic                cfg_data,
    output logic                cfg_ready,
    output logic [NUM_BITS-1:0] sram_out,
    output logic                cfg_done,
    output logic                cfg_error
);

    localparam int CNT_MAX = (NUM_BITS > SYNC_TIMEOUT) ? NUM_BITS : SYNC_TIMEOUT;
    localparam int CW      = clog2(CNT_MAX + 1);

    state_e              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
    logic                par_q, par_d;
    logic                frame_clr, sync_en, shadow_en, commit, fail, xfer;
    logic [6:0]          sync_q;
    logic [NUM_BITS-1:0] shadow_q;

    assign cfg_ready = (state_q == ST_SYNC) || (state_q == ST_LOAD) || (state_q == ST_PARITY);
    assign xfer      = cfg_valid && cfg_ready;
    assign cnt_inc   = cnt_q + CW'(1);

    // Only the seven most recent bits are stored; the eighth is the live input.
    cfg_shift_reg #(.WIDTH(7)) u_sync (
        .clk(clk), .reset(reset), .clr(frame_clr), .en(sync_en), .din(cfg_data), .q(sync_q)
    );

    cfg_shift_reg #(.WIDTH(NUM_BITS)) u_shadow (
        .clk(clk), .reset(reset), .clr(frame_clr), .en(shadow_en), .din(cfg_data), .q(shadow_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            par_q     <= 1'b0;
            sram_out  <= '1;
            cfg_done  <= 1'b0;
            cfg_error <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            if (frame_clr) begin
                cfg_done  <= 1'b0;
                cfg_error <= 1'b0;
            end
            if (commit) begin
                sram_out <= shadow_q;
                cfg_done <= 1'b1;
            end
            if (fail) begin
                cfg_error <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        par_d     = par_q;
        frame_clr = 1'b0;
        sync_en   = 1'b0;
        shadow_en = 1'b0;
        commit    = 1'b0;
        fail      = 1'b0;

        // A start pulse outranks any transfer while a frame is in flight.
        if (cfg_start && (state_q == ST_IDLE || cfg_ready)) begin
            state_d   = ST_SYNC;
            cnt_d     = '0;
            par_d     = 1'b0;
            frame_clr = 1'b1;
        end else begin
            case (state_q)
                ST_SYNC: begin
                    if (xfer) begin
                        sync_en = 1'b1;
                        if ({sync_q, cfg_data} == SYNC_WORD) begin
                            state_d = ST_LOAD;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                            if (cnt_inc == CW'(SYNC_TIMEOUT)) state_d = ST_ERROR;
                        end
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        shadow_en = 1'b1;
                        par_d     = par_q ^ cfg_data;
                        cnt_d     = cnt_inc;
                        if (cnt_inc == CW'(NUM_BITS)) state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    if (xfer) state_d = (par_q ^ cfg_data) ? ST_ERROR : ST_COMMIT;
                end
                ST_COMMIT: begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
                ST_ERROR: begin
                    fail    = 1'b1;
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_sram_loader.sv
// Bench for config_sram_loader (NUM_BITS=8, SYNC_TIMEOUT=16): directed frames
// plus random frames with random gaps, checked against a frame-level model.
module tb_config_sram_loader;

    localparam int         NB = 8;
    localparam int         TO = 16;
    localparam logic [7:0] SW = 8'hB5;

    logic          clk = 1'b0;
    logic          reset, cfg_start, cfg_valid, cfg_data;
    logic          cfg_ready, cfg_done, cfg_error;
    logic [NB-1:0] sram_out;

    int n_checks = 0;
    int n_fail   = 0;

    logic [NB-1:0] exp_sram;
    logic          exp_done, exp_err, exp_ready;
    bit            frame[$];

    always #5 clk = ~clk;

    config_sram_loader #(.NUM_BITS(NB), .SYNC_WORD(SW), .SYNC_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
        .cfg_data(cfg_data), .cfg_ready(cfg_ready), .sram_out(sram_out),
        .cfg_done(cfg_done), .cfg_error(cfg_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) frame.push_back(v[i]);
    endtask

    // Outcome of one frame from the bits offered after cfg_start.
    task automatic predict();
        logic [7:0]    win;
        logic [NB-1:0] pay;
        int            i, misses;
        bit            found, par;
        win = '0; i = 0; misses = 0; found = 0;
        exp_done = 0; exp_err = 0; exp_ready = 0;
        while (i < frame.size()) begin
            win = {win[6:0], frame[i]};
            i++;
            if (win == SW) begin found = 1; break; end
            misses++;
            if (misses == TO) begin exp_err = 1; return; end
        end
        if (!found || (frame.size() - i) < NB + 1) begin
            exp_ready = 1;
            return;
        end
        par = 0;
        for (int k = 0; k < NB; k++) begin
            pay[NB-1-k] = frame[i+k];
            par ^= frame[i+k];
        end
        par ^= frame[i+NB];
        if (par) exp_err = 1;
        else begin exp_done = 1; exp_sram = pay; end
    endtask

    task automatic pulse_start(input logic with_bit);
        cfg_start = 1; cfg_valid = with_bit; cfg_data = with_bit;
        @(posedge clk); #1;
        cfg_start = 0; cfg_valid = 0; cfg_data = 0;
    endtask

    // gap_mode: 0 back-to-back, 1 one idle cycle per bit, 2 random 0-5 idle cycles.
    task automatic send(input int gap_mode);
        int gap;
        foreach (frame[j]) begin
            if (!cfg_ready) break;
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(5, 0));
            repeat (gap) begin @(posedge clk); #1; end
            cfg_valid = 1; cfg_data = frame[j];
            @(posedge clk); #1;
            cfg_valid = 0; cfg_data = 0;
        end
        @(posedge clk); #1;
    endtask

    task automatic check_result(input string tag);
        check({tag, "_sram"},  64'(sram_out),  64'(exp_sram));
        check({tag, "_done"},  64'(cfg_done),  64'(exp_done));
        check({tag, "_error"}, 64'(cfg_error), 64'(exp_err));
        check({tag, "_ready"}, 64'(cfg_ready), 64'(exp_ready));
    endtask

    task automatic run_frame(input string tag, input int gap_mode);
        pulse_start(1'b0);
        check({tag, "_start_ready"}, 64'(cfg_ready), 64'd1);
        check({tag, "_start_done"},  64'(cfg_done),  64'd0);
        predict();
        send(gap_mode);
        check_result(tag);
        frame.delete();
    endtask

    initial begin
        logic [NB-1:0] pay;
        int            pre;
        reset = 1; cfg_start = 0; cfg_valid = 0; cfg_data = 0;
        exp_sram = '1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sram",  64'(sram_out),  64'hFF);
        check("reset_ready", 64'(cfg_ready), 64'd0);
        check("reset_done",  64'(cfg_done),  64'd0);
        check("reset_error", 64'(cfg_error), 64'd0);
        reset = 0;
        @(posedge clk); #1;
        check("idle_sram", 64'(sram_out), 64'hFF);

        push_byte(8'hB5); push_byte(8'h69); frame.push_back(0);
        run_frame("good_69", 0);
        check("good_69_value", 64'(sram_out), 64'h69);

        push_byte(8'hB5); push_byte(8'hA5); frame.push_back(1);
        run_frame("bad_parity", 0);
        check("bad_parity_held", 64'(sram_out), 64'h69);

        for (int i = 0; i < TO; i++) frame.push_back(0);
        run_frame("sync_timeout", 0);

        push_byte(8'hB5); push_byte(8'h69); frame.push_back(0);
        run_frame("toggle_valid", 1);
        check("toggle_valid_value", 64'(sram_out), 64'h69);

        push_byte(8'hB5); push_byte(8'h69); frame.push_back(0);
        run_frame("random_gaps", 2);

        // Abort after four payload bits; the restart pulse carries a bit that must be dropped.
        pulse_start(1'b0);
        push_byte(8'hB5); frame.push_back(1); frame.push_back(0);
        frame.push_back(1); frame.push_back(1);
        send(0);
        check("partial_ready", 64'(cfg_ready), 64'd1);
        check("partial_sram",  64'(sram_out),  64'(exp_sram));
        frame.delete();
        pulse_start(1'b1);
        push_byte(8'hB5); push_byte(8'h3C); frame.push_back(0);
        predict();
        send(0);
        check_result("restart_3c");
        check("restart_3c_value", 64'(sram_out), 64'h3C);
        frame.delete();

        pulse_start(1'b0);
        push_byte(8'hB5); frame.push_back(0); frame.push_back(1);
        frame.push_back(1); frame.push_back(0);
        send(0);
        frame.delete();
        reset = 1;
        @(posedge clk); #1;
        reset = 0;
        exp_sram = '1;
        check("midreset_sram",  64'(sram_out),  64'hFF);
        check("midreset_ready", 64'(cfg_ready), 64'd0);
        check("midreset_done",  64'(cfg_done),  64'd0);
        check("midreset_error", 64'(cfg_error), 64'd0);

        for (int f = 0; f < 30; f++) begin
            pre = $urandom_range(20, 0);
            for (int k = 0; k < pre; k++) frame.push_back(bit'($urandom_range(1, 0)));
            if ($urandom_range(9, 0) != 0) push_byte(SW);
            pay = NB'($urandom);
            push_byte(pay);
            frame.push_back((^pay) ^ ($urandom_range(3, 0) == 0));
            run_frame($sformatf("rand%0d", f), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
